// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared types and the LIF update arithmetic for the neuron scheduler.
// The update function is width-generic so the scheduler and other tile blocks can reuse it.
package lif_neuron_scheduler_pkg;

  localparam int N_NEUR_DEF = 4;
  localparam int W_DEF      = 6;
  localparam int ID_W_DEF   = $clog2(N_NEUR_DEF);
  localparam int LIF_MAXW   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_UPDATE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_LEAK   = 3'd4
  } lif_state_e;

  // cur + (f ? 0 : s>>1), saturated to 2^w-1 (w <= LIF_MAXW).
  function automatic logic [LIF_MAXW-1:0] lif_sat_add(
    input logic [LIF_MAXW-1:0] cur,
    input logic [LIF_MAXW-1:0] s,
    input logic                f,
    input int unsigned         w
  );
    logic [LIF_MAXW:0]   sum;
    logic [LIF_MAXW:0]   max_v;
    logic [LIF_MAXW-1:0] leak_term;
    leak_term = f ? '0 : (s >> 1);
    max_v     = (LIF_MAXW+1)'((64'd1 << w) - 64'd1);
    sum       = {1'b0, cur} + {1'b0, leak_term};
    if (sum > max_v) sum = max_v;
    return sum[LIF_MAXW-1:0];
  endfunction

endpackage

// File: rtl/lif_neuron_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// N must be a power of two so the index wraps naturally.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF neuron scheduler: round-robin request grant, one shared
// update datapath, spike event output, periodic leak sweeps and threshold config.
module lif_neuron_scheduler
  import lif_neuron_scheduler_pkg::*;
#(
  parameter int N_NEUR      = N_NEUR_DEF,
  parameter int W           = W_DEF,
  parameter int DEFAULT_THR = 32,
  parameter int ID_W        = $clog2(N_NEUR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_NEUR-1:0]   req_valid,
  input  logic [N_NEUR*W-1:0] req_current,
  output logic [N_NEUR-1:0]   req_ready,
  input  logic                leak_tick,
  input  logic                cfg_we,
  input  logic [ID_W-1:0]     cfg_id,
  input  logic [W-1:0]        cfg_thr,
  output logic                spike_valid,
  output logic [ID_W-1:0]     spike_id,
  input  logic                spike_ready,
  output logic                busy,
  output logic [N_NEUR*W-1:0] state_dbg,
  output lif_state_e          fsm_dbg
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high.
  // Requesters hold req_valid/req_current until req_ready; the scheduler holds
  // spike_valid/spike_id stable until spike_ready.

  lif_state_e fsm_q, fsm_d;

  logic [W-1:0]      st_mem  [N_NEUR];
  logic [W-1:0]      thr_mem [N_NEUR];
  logic [N_NEUR-1:0] flag_mem;

  logic [ID_W-1:0] rr_ptr_q, g_q, leak_idx_q, spike_id_q;
  logic [W-1:0]    cur_q, s_q, t_q;
  logic            f_q;
  logic            leak_pend_q;

  logic [N_NEUR-1:0] arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              grant_fire;

  logic [LIF_MAXW-1:0] sum_wide;
  logic [W-1:0]        upd_sum;
  logic                upd_fire;

  rr_arbiter #(
    .N     (N_NEUR),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Pending leak sweeps win over requests, so no grant while one is queued.
  assign grant_fire = (fsm_q == ST_IDLE) && !leak_pend_q && arb_any && !reset;
  assign req_ready  = grant_fire ? arb_grant : '0;

  always_comb begin
    sum_wide = lif_sat_add(LIF_MAXW'(cur_q), LIF_MAXW'(s_q), f_q, W);
    upd_sum  = sum_wide[W-1:0];
    upd_fire = (upd_sum >= t_q);
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (leak_pend_q)  fsm_d = ST_LEAK;
        else if (arb_any) fsm_d = ST_LOAD;
      end
      ST_LOAD:   fsm_d = ST_UPDATE;
      ST_UPDATE: fsm_d = upd_fire ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (spike_ready) fsm_d = ST_IDLE;
      ST_LEAK:   if (leak_idx_q == ID_W'(N_NEUR-1)) fsm_d = ST_IDLE;
      default:   fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEUR; i++) begin
        st_mem[i]  <= '0;
        thr_mem[i] <= W'(DEFAULT_THR);
      end
      flag_mem    <= '0;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      leak_idx_q  <= '0;
      spike_id_q  <= '0;
      cur_q       <= '0;
      s_q         <= '0;
      t_q         <= '0;
      f_q         <= 1'b0;
      leak_pend_q <= 1'b0;
    end else begin
      if (cfg_we) thr_mem[cfg_id] <= cfg_thr;

      // A tick landing on the cycle the sweep starts merges into that sweep.
      if (fsm_q == ST_IDLE && leak_pend_q) leak_pend_q <= 1'b0;
      else if (leak_tick)                  leak_pend_q <= 1'b1;

      if (grant_fire) begin
        g_q      <= arb_idx;
        cur_q    <= req_current[arb_idx*W +: W];
        rr_ptr_q <= arb_idx + 1'b1;
      end

      case (fsm_q)
        ST_IDLE: leak_idx_q <= '0;
        ST_LOAD: begin
          s_q <= st_mem[g_q];
          f_q <= flag_mem[g_q];
          t_q <= (cfg_we && cfg_id == g_q) ? cfg_thr : thr_mem[g_q];
        end
        ST_UPDATE: begin
          st_mem[g_q]   <= upd_fire ? '0 : upd_sum;
          flag_mem[g_q] <= upd_fire;
          if (upd_fire) spike_id_q <= g_q;
        end
        ST_LEAK: begin
          if (st_mem[leak_idx_q] != '0) st_mem[leak_idx_q] <= st_mem[leak_idx_q] - 1'b1;
          leak_idx_q <= leak_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < N_NEUR; i++) state_dbg[i*W +: W] = st_mem[i];
  end

  assign spike_valid = (fsm_q == ST_EMIT);
  assign spike_id    = spike_id_q;
  assign busy        = (fsm_q != ST_IDLE);
  assign fsm_dbg     = fsm_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed self-checking bench for lif_neuron_scheduler with hand-computed expectations.
module tb_lif_neuron_scheduler;
  import lif_neuron_scheduler_pkg::*;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_current;
  logic [N-1:0]   req_ready;
  logic           leak_tick;
  logic           cfg_we;
  logic [1:0]     cfg_id;
  logic [W-1:0]   cfg_thr;
  logic           spike_valid;
  logic [1:0]     spike_id;
  logic           spike_ready;
  logic           busy;
  logic [N*W-1:0] state_dbg;
  lif_state_e     fsm_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [1:0] exp_q[$];

  lif_neuron_scheduler #(.N_NEUR(N), .W(W), .DEFAULT_THR(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_current (req_current),
    .req_ready   (req_ready),
    .leak_tick   (leak_tick),
    .cfg_we      (cfg_we),
    .cfg_id      (cfg_id),
    .cfg_thr     (cfg_thr),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .busy        (busy),
    .state_dbg   (state_dbg),
    .fsm_dbg     (fsm_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] st(input int i);
    return state_dbg[i*W +: W];
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = '0;
    req_current = '0;
    leak_tick   = 1'b0;
    cfg_we      = 1'b0;
    cfg_id      = '0;
    cfg_thr     = '0;
    spike_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // driver: present a request, wait (bounded) for its grant, return in the LOAD cycle
  task automatic request(input int lane, input logic [W-1:0] cur, output int waited);
    req_valid[lane]           = 1'b1;
    req_current[lane*W +: W]  = cur;
    waited = 0;
    #1;
    while (req_ready[lane] !== 1'b1 && waited < 12) begin
      step();
      #1;
      waited++;
    end
    check_eq($sformatf("grant_l%0d", lane), 32'(req_ready), 32'(1 << lane));
    step();
    req_valid[lane] = 1'b0;
  endtask

  initial begin
    int w;
    int last;
    int n;
    int idx;
    logic [1:0] e;

    // reset state and basic integrate
    do_reset();
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_spike_valid", 32'(spike_valid), 0);
    check_eq("rst_spike_id", 32'(spike_id), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_states", 32'(state_dbg), 0);
    check_eq("rst_fsm", 32'(fsm_dbg), 32'(ST_IDLE));

    request(0, 6'd10, w);
    check_eq("first_grant_lat", w, 0);
    step(); step();
    check_eq("int1_state0", 32'(st(0)), 10);
    check_eq("int1_nospike", 32'(spike_valid), 0);
    check_eq("int1_idle", 32'(busy), 0);
    request(0, 6'd10, w);
    check_eq("back2back_lat", w, 0);
    step(); step();
    check_eq("int2_state0", 32'(st(0)), 15);
    request(0, 6'd10, w);
    step(); step();
    check_eq("int3_state0", 32'(st(0)), 17);

    // firing and post-fire update without the leak term
    request(2, 6'd40, w);
    step(); step();
    check_eq("fire_valid", 32'(spike_valid), 1);
    check_eq("fire_id", 32'(spike_id), 2);
    check_eq("fire_state2", 32'(st(2)), 0);
    step();
    check_eq("fire_accepted", 32'(spike_valid), 0);
    request(2, 6'd5, w);
    step(); step();
    check_eq("postfire_state2", 32'(st(2)), 5);
    request(2, 6'd5, w);
    step(); step();
    check_eq("halfleak_state2", 32'(st(2)), 7);

    // round-robin fairness with all lanes valid (scoreboard of grant order)
    do_reset();
    for (int k = 0; k < 16; k++) exp_q.push_back(2'(k % 4));
    req_current = {4{6'd1}};
    req_valid   = 4'hF;
    last = -1;
    n    = 0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      #1;
      if (req_ready != '0) begin
        idx = 0;
        for (int b = 0; b < N; b++) if (req_ready[b]) idx = b;
        e = exp_q.pop_front();
        check_eq("rr_order", idx, 32'(e));
        check_eq("rr_onehot", 32'($onehot(req_ready)), 1);
        if (last >= 0) check_eq("rr_gap", cyc - last, 3);
        last = cyc;
        n++;
      end
      step();
    end
    req_valid = '0;
    check_eq("rr_count", n, 16);
    check_eq("rr_queue_empty", exp_q.size(), 0);
    step(); step();
    for (int i = 0; i < N; i++) check_eq($sformatf("rr_state%0d", i), 32'(st(i)), 1);

    // spike backpressure stalls the scheduler
    spike_ready = 1'b0;
    request(3, 6'd63, w);
    req_valid[0]        = 1'b1;
    req_current[0 +: W] = 6'd6;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_valid", 32'(spike_valid), 1);
      check_eq("bp_id", 32'(spike_id), 3);
      check_eq("bp_no_grant", 32'(req_ready), 0);
      step();
    end
    spike_ready = 1'b1;
    #1;
    check_eq("bp_release_valid", 32'(spike_valid), 1);
    step();
    #1;
    check_eq("bp_resume_grant", 32'(req_ready), 32'(4'b0001));
    step();
    req_valid = '0;
    step(); step();
    check_eq("bp_state0", 32'(st(0)), 6);
    check_eq("bp_state3", 32'(st(3)), 0);

    // leak sweep: two back-to-back ticks collapse into one sweep
    do_reset();
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_thr = 6'd63;
    step();
    cfg_we = 1'b0;
    request(0, 6'd3, w);  step(); step();
    request(2, 6'd62, w); step(); step();
    request(3, 6'd1, w);  step(); step();
    check_eq("pre_leak_states", 32'(state_dbg), 32'({6'd1, 6'd62, 6'd0, 6'd3}));
    leak_tick = 1'b1;
    step();
    step();
    leak_tick = 1'b0;
    check_eq("leak_fsm", 32'(fsm_dbg), 32'(ST_LEAK));
    step(); step(); step(); step();
    check_eq("leak_done_idle", 32'(busy), 0);
    check_eq("leak_states", 32'(state_dbg), 32'({6'd0, 6'd61, 6'd0, 6'd2}));
    for (int k = 0; k < 6; k++) step();
    check_eq("leak_single_sweep", 32'(state_dbg), 32'({6'd0, 6'd61, 6'd0, 6'd2}));

    // pending leak delays a request until the sweep ends
    leak_tick = 1'b1;
    step();
    leak_tick = 1'b0;
    request(1, 6'd2, w);
    check_eq("leak_delays_grant", w, 5);
    step(); step();
    check_eq("after_leak_states", 32'(state_dbg), 32'({6'd0, 6'd60, 6'd2, 6'd1}));

    // saturation: 40 + 60/2 = 70 saturates to 63 and reaches threshold 63
    request(2, 6'd40, w);
    step(); step();
    check_eq("sat_fire", 32'(spike_valid), 1);
    check_eq("sat_id", 32'(spike_id), 2);
    check_eq("sat_state2", 32'(st(2)), 0);
    step();

    // threshold forwarding during LOAD, and no forwarding after LOAD
    do_reset();
    request(1, 6'd8, w);
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_thr = 6'd8;
    step();
    cfg_we = 1'b0;
    step();
    check_eq("fwd_fire", 32'(spike_valid), 1);
    check_eq("fwd_id", 32'(spike_id), 1);
    step();
    request(1, 6'd8, w);
    step();
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_thr = 6'd9;
    step();
    cfg_we = 1'b0;
    check_eq("latched_thr_fire", 32'(spike_valid), 1);
    step();

    // reset mid-UPDATE restores states and thresholds
    request(0, 6'd20, w);
    step(); step();
    check_eq("pre_reset_state0", 32'(st(0)), 20);
    request(3, 6'd50, w);
    step();
    reset = 1'b1;
    step();
    check_eq("rst_upd_busy", 32'(busy), 0);
    check_eq("rst_upd_spike", 32'(spike_valid), 0);
    check_eq("rst_upd_states", 32'(state_dbg), 0);
    reset = 1'b0;
    request(1, 6'd31, w);
    step(); step();
    check_eq("rst_thr_nofire", 32'(spike_valid), 0);
    check_eq("rst_thr_state1", 32'(st(1)), 31);

    // reset mid-EMIT discards the event
    spike_ready = 1'b0;
    request(2, 6'd40, w);
    step(); step();
    check_eq("emit_pre_reset", 32'(spike_valid), 1);
    reset = 1'b1;
    step();
    check_eq("emit_reset_valid", 32'(spike_valid), 0);
    check_eq("emit_reset_id", 32'(spike_id), 0);
    reset       = 1'b0;
    spike_ready = 1'b1;
    step();
    check_eq("emit_reset_stays", 32'(spike_valid), 0);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
